issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/reg_scoreboard.sv | 37 +++
 rtl/issue_scheduler.sv | 129 ++++++++++++
 tb/tb_issue_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/FU counts, decoded-instruction record and
// the issue scheduler state encoding.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned NUM_FU   = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned FU_W     = 4;

  typedef struct packed {
    logic [2*REG_W-1:0] readregs;
    logic [1:0]         read_ena;
    logic [REG_W-1:0]   writereg;
    logic               write_ena;
    logic [7:0]         flagouts;
    logic [FU_W-1:0]    fuid;
    logic               halt;
  } dec_instr_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } sched_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending-write bit per register, issue-set has
// priority over a same-cycle writeback clear of the same register.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_reg,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic [NUM_REGS-1:0] eff_busy,
  output logic [NUM_REGS-1:0] busy_next
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wb_valid) clr_mask[wb_reg] = 1'b1;
    if (set_en)   set_mask[set_reg] = 1'b1;
    eff_busy = busy_q & ~clr_mask;
    busy_d   = eff_busy | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy      = busy_q;
  assign busy_next = busy_d;

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-entry issue stage: holds one decoded instruction, blocks it
// on RAW/WAW scoreboard hazards and drains the machine on a halt instruction.
module issue_scheduler
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_readregs,
  input  logic [1:0]  in_read_ena,
  input  logic [3:0]  in_writereg,
  input  logic        in_write_ena,
  input  logic [7:0]  in_flagouts,
  input  logic [3:0]  in_fuid,
  input  logic        in_halt,
  input  logic [15:0] fu_ready,
  output logic        issue_valid,
  output logic [7:0]  issue_readregs,
  output logic [1:0]  issue_read_ena,
  output logic [3:0]  issue_writereg,
  output logic        issue_write_ena,
  output logic [7:0]  issue_flagouts,
  output logic [3:0]  issue_fuid,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  output logic [15:0] busy_regs,
  output logic        halted,
  output logic [15:0] stall_count
);

  sched_state_e  state_q, state_d;
  logic          hold_valid_q, hold_valid_d;
  dec_instr_t    hold_q, hold_d, in_instr, hold_out;
  logic [15:0]   stall_q, stall_d;
  logic [NUM_REGS-1:0] eff_busy, busy_next;
  logic          hazard, fire, accept;
  logic          accept_ok, can_issue;

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (fire & hold_q.write_ena),
    .set_reg   (hold_q.writereg),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .busy      (busy_regs),
    .eff_busy  (eff_busy),
    .busy_next (busy_next)
  );

  always_comb begin
    in_instr.readregs  = in_readregs;
    in_instr.read_ena  = in_read_ena;
    in_instr.writereg  = in_writereg;
    in_instr.write_ena = in_write_ena;
    in_instr.flagouts  = in_flagouts;
    in_instr.fuid      = in_fuid;
    in_instr.halt      = in_halt;
  end

  always_comb begin
    hazard = (hold_q.read_ena[0] & eff_busy[hold_q.readregs[3:0]]) |
             (hold_q.read_ena[1] & eff_busy[hold_q.readregs[7:4]]) |
             (hold_q.write_ena   & eff_busy[hold_q.writereg]);
    issue_valid = hold_valid_q & ~hazard & can_issue;
    fire        = issue_valid & fu_ready[hold_q.fuid];
    in_ready    = accept_ok & (~hold_valid_q | fire);
    accept      = in_valid & in_ready;
  end

  // Halt instructions are consumed at accept and never enter the hold register.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (fire) hold_valid_d = 1'b0;
    if (accept && !in_halt) begin
      hold_valid_d = 1'b1;
      hold_d       = in_instr;
    end
    stall_d = stall_q;
    if (hold_valid_q && !fire && stall_q != '1) stall_d = stall_q + 16'd1;
  end

  // Drain completes on the edge where the machine becomes empty, so HALTED
  // shows up the cycle after the last writeback.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (accept && in_halt) state_d = S_DRAIN;
      S_DRAIN:  if (busy_next == '0 && !hold_valid_d) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
    end
  end

  always_comb begin
    accept_ok = (state_q == S_RUN);
    can_issue = (state_q != S_HALTED);
    halted    = (state_q == S_HALTED);
  end

  always_comb begin
    hold_out        = hold_valid_q ? hold_q : '0;
    issue_readregs  = hold_out.readregs;
    issue_read_ena  = hold_out.read_ena;
    issue_writereg  = hold_out.writereg;
    issue_write_ena = hold_out.write_ena;
    issue_flagouts  = hold_out.flagouts;
    issue_fuid      = hold_out.fuid;
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_write_ena, in_halt;
  logic [7:0]  in_readregs, in_flagouts;
  logic [1:0]  in_read_ena;
  logic [3:0]  in_writereg, in_fuid;
  logic [15:0] fu_ready;
  logic        issue_valid, issue_write_ena;
  logic [7:0]  issue_readregs, issue_flagouts;
  logic [1:0]  issue_read_ena;
  logic [3:0]  issue_writereg, issue_fuid;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] busy_regs, stall_count;
  logic        halted;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_readregs(in_readregs), .in_read_ena(in_read_ena),
    .in_writereg(in_writereg), .in_write_ena(in_write_ena),
    .in_flagouts(in_flagouts), .in_fuid(in_fuid), .in_halt(in_halt),
    .fu_ready(fu_ready), .issue_valid(issue_valid),
    .issue_readregs(issue_readregs), .issue_read_ena(issue_read_ena),
    .issue_writereg(issue_writereg), .issue_write_ena(issue_write_ena),
    .issue_flagouts(issue_flagouts), .issue_fuid(issue_fuid),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .busy_regs(busy_regs),
    .halted(halted), .stall_count(stall_count)
  );

  typedef struct {
    bit        chk;
    bit        rst, in_valid;
    bit [3:0]  rs0, rs1;
    bit [1:0]  re;
    bit [3:0]  wr;
    bit        we;
    bit [7:0]  flags;
    bit [3:0]  fuid;
    bit        halt;
    bit [15:0] fu_ready;
    bit        wb_valid;
    bit [3:0]  wb_reg;
    bit        e_ready, e_iv, e_halted;
    bit [15:0] e_busy, e_stall;
  } vec_t;

  typedef struct {
    bit [3:0] rs0, rs1;
    bit [1:0] re;
    bit [3:0] wr;
    bit       we;
    bit [7:0] flags;
    bit [3:0] fuid;
  } op_t;

  // Reference model: pending-write set, program-order queue (depth <= 1), mode.
  bit          m_busy[16];
  op_t         m_hold[$];
  int          m_mode;  // 0 running, 1 draining, 2 halted
  int unsigned m_stall;
  bit          m_valid = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  function automatic vec_t mkv(bit r, bit iv, bit [3:0] rs0, bit [3:0] rs1, bit [1:0] re,
                               bit [3:0] wr, bit we, bit [3:0] fuid, bit halt,
                               bit [15:0] fr, bit wbv, bit [3:0] wbr);
    vec_t v;
    v.chk = 1'b0; v.rst = r; v.in_valid = iv; v.rs0 = rs0; v.rs1 = rs1; v.re = re;
    v.wr = wr; v.we = we; v.fuid = fuid; v.halt = halt; v.fu_ready = fr;
    v.wb_valid = wbv; v.wb_reg = wbr; v.flags = {fuid, wr} ^ 8'h5A;
    v.e_ready = 1'b0; v.e_iv = 1'b0; v.e_halted = 1'b0; v.e_busy = '0; v.e_stall = '0;
    return v;
  endfunction

  function automatic vec_t idle(bit [15:0] fr, bit wbv, bit [3:0] wbr);
    return mkv(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, fr, wbv, wbr);
  endfunction

  function automatic vec_t ex(vec_t v, bit r, bit iv, bit h, bit [15:0] b, bit [15:0] s);
    vec_t o;
    o = v; o.chk = 1'b1; o.e_ready = r; o.e_iv = iv; o.e_halted = h; o.e_busy = b; o.e_stall = s;
    return o;
  endfunction

  function automatic bit [15:0] m_busy_vec();
    bit [15:0] b;
    b = '0;
    for (int r = 0; r < 16; r++) b[r] = m_busy[r];
    return b;
  endfunction

  function automatic void model_out(input vec_t v, output bit ready, output bit iv,
                                    output bit fire, output bit hlt);
    bit  eff[16];
    bit  hz;
    op_t h;
    for (int r = 0; r < 16; r++) eff[r] = m_busy[r] && !(v.wb_valid && v.wb_reg == r);
    iv = 1'b0;
    fire = 1'b0;
    if (m_hold.size() != 0 && m_mode != 2) begin
      h = m_hold[0];
      hz = (h.re[0] && eff[h.rs0]) || (h.re[1] && eff[h.rs1]) || (h.we && eff[h.wr]);
      iv = !hz;
      fire = iv && v.fu_ready[h.fuid];
    end
    ready = (m_mode == 0) && (m_hold.size() == 0 || fire);
    hlt = (m_mode == 2);
  endfunction

  function automatic bit [31:0] m_fields();
    op_t h;
    if (m_hold.size() == 0) return '0;
    h = m_hold[0];
    return 32'({h.rs1, h.rs0, h.re, h.wr, h.we, h.flags, h.fuid});
  endfunction

  function automatic void model_update(vec_t v);
    bit  ready, iv, fire, hlt, any;
    op_t o;
    model_out(v, ready, iv, fire, hlt);
    if (v.rst) begin
      for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
      m_hold.delete();
      m_mode = 0;
      m_stall = 0;
      return;
    end
    if (m_hold.size() != 0 && !fire && m_stall < 65535) m_stall++;
    if (v.wb_valid) m_busy[v.wb_reg] = 1'b0;
    if (fire) begin
      if (m_hold[0].we) m_busy[m_hold[0].wr] = 1'b1;
      void'(m_hold.pop_front());
    end
    if (v.in_valid && ready) begin
      if (v.halt) m_mode = 1;
      else begin
        o.rs0 = v.rs0; o.rs1 = v.rs1; o.re = v.re; o.wr = v.wr; o.we = v.we;
        o.flags = v.flags; o.fuid = v.fuid;
        m_hold.push_back(o);
      end
    end else if (m_mode == 1) begin
      any = 1'b0;
      for (int r = 0; r < 16; r++) any |= m_busy[r];
      if (!any && m_hold.size() == 0) m_mode = 2;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input vec_t v);
    bit rdy, iv, fire, hlt;
    rst = v.rst; in_valid = v.in_valid; in_readregs = {v.rs1, v.rs0};
    in_read_ena = v.re; in_writereg = v.wr; in_write_ena = v.we;
    in_flagouts = v.flags; in_fuid = v.fuid; in_halt = v.halt;
    fu_ready = v.fu_ready; wb_valid = v.wb_valid; wb_reg = v.wb_reg;
    @(negedge clk);
    if (m_valid) begin
      model_out(v, rdy, iv, fire, hlt);
      check("model_in_ready", 32'(in_ready), 32'(rdy));
      check("model_issue_valid", 32'(issue_valid), 32'(iv));
      check("model_halted", 32'(halted), 32'(hlt));
      check("model_busy_regs", 32'(busy_regs), 32'(m_busy_vec()));
      check("model_stall_count", 32'(stall_count), m_stall);
      check("model_issue_fields", 32'({issue_readregs, issue_read_ena, issue_writereg,
            issue_write_ena, issue_flagouts, issue_fuid}), m_fields());
    end
    if (v.chk) begin
      check("tbl_in_ready", 32'(in_ready), 32'(v.e_ready));
      check("tbl_issue_valid", 32'(issue_valid), 32'(v.e_iv));
      check("tbl_halted", 32'(halted), 32'(v.e_halted));
      check("tbl_busy_regs", 32'(busy_regs), 32'(v.e_busy));
      check("tbl_stall_count", 32'(stall_count), 32'(v.e_stall));
    end
    @(posedge clk);
    if (m_valid || v.rst) begin
      model_update(v);
      m_valid = 1'b1;
    end
    #1;
    cyc++;
  endtask

  localparam bit [15:0] ALL = 16'hFFFF;
  localparam bit [15:0] NO2 = 16'hFFFB;

  initial begin
    vec_t tbl[$];
    vec_t v;
    vec_t noop_in;

    noop_in = mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd3, 1'b0, ALL, 1'b0, 4'd0);

    // reset, ALU r3=r1+r2, RAW on r3 unblocked by same-cycle writeback
    tbl.push_back(mkv(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, ALL, 1'b0, 4'd0));
    tbl.push_back(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    tbl.push_back(ex(mkv(1'b0, 1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 4'd0, 1'b0, ALL, 1'b0, 4'd0),
                     1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    tbl.push_back(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0));
    tbl.push_back(ex(mkv(1'b0, 1'b1, 4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 4'd1, 1'b0, ALL, 1'b0, 4'd0),
                     1'b1, 1'b0, 1'b0, 16'h0008, 16'd0));
    tbl.push_back(ex(idle(ALL, 1'b0, 4'd0), 1'b0, 1'b0, 1'b0, 16'h0008, 16'd0));
    tbl.push_back(ex(idle(ALL, 1'b1, 4'd3), 1'b1, 1'b1, 1'b0, 16'h0008, 16'd1));
    // mult on fuid 2 blocked by fu_ready for three cycles
    tbl.push_back(mkv(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b0, ALL, 1'b0, 4'd0));
    tbl.push_back(ex(mkv(1'b0, 1'b1, 4'd4, 4'd5, 2'b11, 4'd6, 1'b1, 4'd2, 1'b0, NO2, 1'b0, 4'd0),
                     1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    v = noop_in; v.fu_ready = NO2;
    tbl.push_back(ex(v, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0));
    tbl.push_back(ex(v, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd1));
    tbl.push_back(ex(v, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd2));
    tbl.push_back(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b1, 1'b0, 16'h0000, 16'd3));
    tbl.push_back(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0040, 16'd3));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // set on issue wins over same-cycle writeback of r5
    step(idle(ALL, 1'b0, 4'd0));
    v = idle(ALL, 1'b0, 4'd0); v.rst = 1'b1; step(v);
    step(ex(mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 4'd0, 1'b0, ALL, 1'b0, 4'd0),
            1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    step(ex(mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 4'd1, 1'b0, ALL, 1'b0, 4'd0),
            1'b1, 1'b1, 1'b0, 16'h0000, 16'd0));
    step(ex(idle(ALL, 1'b0, 4'd0), 1'b0, 1'b0, 1'b0, 16'h0020, 16'd0));
    step(ex(idle(ALL, 1'b1, 4'd5), 1'b1, 1'b1, 1'b0, 16'h0020, 16'd1));
    step(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0020, 16'd1));

    // halt behind a write to r7: drain, then halted the cycle after wb r7
    v = idle(ALL, 1'b0, 4'd0); v.rst = 1'b1; step(v);
    step(ex(mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 4'd1, 1'b0, ALL, 1'b0, 4'd0),
            1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    step(ex(mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 4'd0, 1'b1, ALL, 1'b0, 4'd0),
            1'b1, 1'b1, 1'b0, 16'h0000, 16'd0));
    step(ex(noop_in, 1'b0, 1'b0, 1'b0, 16'h0080, 16'd0));
    step(ex(noop_in, 1'b0, 1'b0, 1'b0, 16'h0080, 16'd0));
    v = noop_in; v.wb_valid = 1'b1; v.wb_reg = 4'd7;
    step(ex(v, 1'b0, 1'b0, 1'b0, 16'h0080, 16'd0));
    step(ex(noop_in, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0));
    step(ex(noop_in, 1'b0, 1'b0, 1'b1, 16'h0000, 16'd0));

    // reset mid-operation with r4 busy and a dependent instruction held
    v = idle(ALL, 1'b0, 4'd0); v.rst = 1'b1; step(v);
    step(ex(mkv(1'b0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 4'd0, 1'b0, ALL, 1'b0, 4'd0),
            1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));
    step(ex(mkv(1'b0, 1'b1, 4'd4, 4'd0, 2'b01, 4'd0, 1'b0, 4'd2, 1'b0, ALL, 1'b0, 4'd0),
            1'b1, 1'b1, 1'b0, 16'h0000, 16'd0));
    step(ex(idle(ALL, 1'b0, 4'd0), 1'b0, 1'b0, 1'b0, 16'h0010, 16'd0));
    v = noop_in; v.rst = 1'b1; v.wb_valid = 1'b1; v.wb_reg = 4'd9; step(v);
    step(ex(idle(ALL, 1'b0, 4'd0), 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0));

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit [3:0] pick;
      v = mkv(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
              4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 79) == 0),
              ($urandom_range(0, 2) == 0) ? 16'($urandom) : ALL,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      v.flags = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pick = 4'($urandom_range(0, 15));
        for (int k = 0; k < 16; k++)
          if (m_busy[4'(pick + 4'(k))]) begin
            v.wb_reg = 4'(pick + 4'(k));
            break;
          end
      end
      v.rst = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
